// File: rtl/rv_pkg.sv
// Shared RV32I encoding definitions.
//   - opcode constants, identical to the ones the control decoder matches on
//   - funct3 values the encoder forces for load/store/branch
//   - kind_e: the request kind carried on in_kind of rv_instr_encoder
//   - NOP_WORD: addi x0, x0, 0, emitted for illegal requests
//   - fits_signed(): true when a 32-bit value survives truncation to nbits
//     followed by sign extension
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SRX  = 3'b101;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        K_R   = 3'd0,
        K_IMM = 3'd1,
        K_LW  = 3'd2,
        K_SW  = 3'd3,
        K_BEQ = 3'd4,
        K_LUI = 3'd5,
        K_JAL = 3'd6,
        K_ILL = 3'd7
    } kind_e;

    // Every bit from position nbits-1 upward must equal the sign bit.
    function automatic logic fits_signed(input logic [31:0] v, input int nbits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if ((i >= nbits - 1) && (v[i] != v[31])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/rv_imm_pack.sv
// Combinational immediate placement.
// Ports:
//   kind      in  3   request kind (kind_e encoding)
//   funct3    in  3   selects the shift form of ALU-immediate
//   funct7b5  in  1   becomes imm[10] of ALU-immediate shifts
//   imm       in  32  byte offset / value from the request
//   imm_bits  out 32  immediate bits already scattered into their
//                     instruction positions; all other bits zero
//   range_err out 1   immediate not representable (bits would be lost)
module rv_imm_pack
    import rv_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        range_err
);

    always_comb begin
        imm_bits  = '0;
        range_err = 1'b0;
        case (kind_e'(kind))
            K_IMM: begin
                if (funct3 == F3_SLL || funct3 == F3_SRX) begin
                    // Shifts: upper immediate carries the arithmetic flag only.
                    imm_bits[31:20] = {1'b0, funct7b5, 5'b00000, imm[4:0]};
                    range_err       = |imm[31:5];
                end else begin
                    imm_bits[31:20] = imm[11:0];
                    range_err       = !fits_signed(imm, 12);
                end
            end
            K_LW: begin
                imm_bits[31:20] = imm[11:0];
                range_err       = !fits_signed(imm, 12);
            end
            K_SW: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
                range_err       = !fits_signed(imm, 12);
            end
            K_BEQ: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
                range_err       = !fits_signed(imm, 13) || imm[0];
            end
            K_LUI: begin
                imm_bits[31:12] = imm[31:12];
                range_err       = |imm[11:0];
            end
            K_JAL: begin
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
                range_err       = !fits_signed(imm, 21) || imm[0];
            end
            default: begin
                // R-type has no immediate; illegal kind is handled by the top.
            end
        endcase
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// Field-level request -> RV32I machine word, written to sequential
// instruction-memory word addresses through a one-entry output register.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid / in_ready     request handshake
//   in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm
//                           request fields
//   out_valid / out_ready   encoded-word handshake toward the imem write port
//   out_instr, out_addr     encoded word and its word address
//   out_err                 encoding error flag for out_instr
//   count                   words accepted since reset (saturates at capacity)
//   full                    capacity reached; no further requests accepted
module rv_instr_encoder
    import rv_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [ADDR_W:0]   count,
    output logic              full
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    logic              out_valid_reg;
    logic [31:0]       out_instr_reg;
    logic [ADDR_W-1:0] out_addr_reg;
    logic              out_err_reg;
    logic [ADDR_W:0]   count_reg;

    logic [31:0] imm_bits;
    logic        range_err;
    logic [31:0] instr_next;
    logic        err_next;
    logic        accept;

    rv_imm_pack u_imm_pack (
        .kind      (in_kind),
        .funct3    (in_funct3),
        .funct7b5  (in_funct7b5),
        .imm       (in_imm),
        .imm_bits  (imm_bits),
        .range_err (range_err)
    );

    // count never exceeds 2**ADDR_W, so its top bit alone signals capacity.
    assign full     = count_reg[ADDR_W];
    assign in_ready = !full && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    // Register/opcode fields; immediate bits are OR-ed in from rv_imm_pack.
    always_comb begin
        instr_next = NOP_WORD;
        err_next   = range_err;
        case (kind_e'(in_kind))
            K_R:   instr_next = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1,
                                 in_funct3, in_rd, OP_R};
            K_IMM: instr_next = imm_bits | {12'b0, in_rs1, in_funct3, in_rd, OP_IMM};
            K_LW:  instr_next = imm_bits | {12'b0, in_rs1, F3_WORD, in_rd, OP_LOAD};
            K_SW:  instr_next = imm_bits | {7'b0, in_rs2, in_rs1, F3_WORD, 5'b0, OP_STORE};
            K_BEQ: instr_next = imm_bits | {7'b0, in_rs2, in_rs1, F3_BEQ, 5'b0, OP_BRANCH};
            K_LUI: instr_next = imm_bits | {20'b0, in_rd, OP_LUI};
            K_JAL: instr_next = imm_bits | {20'b0, in_rd, OP_JAL};
            default: begin
                instr_next = NOP_WORD;
                err_next   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_instr_reg <= '0;
            out_addr_reg  <= BASE_ADDR;
            out_err_reg   <= 1'b0;
            count_reg     <= '0;
        end else if (accept) begin
            // Also covers accept-while-draining: the register simply reloads.
            out_valid_reg <= 1'b1;
            out_instr_reg <= instr_next;
            out_addr_reg  <= BASE_ADDR + count_reg[ADDR_W-1:0];
            out_err_reg   <= err_next;
            count_reg     <= count_reg + COUNT_ONE;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_instr = out_instr_reg;
    assign out_addr  = out_addr_reg;
    assign out_err   = out_err_reg;
    assign count     = count_reg;

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Inverse of the control decoder: turns a field-level instruction request (kind, registers, funct, immediate) into a 32-bit RV32I machine word.
- Writes each encoded word to sequential instruction-memory word addresses.
- Used by the program loader and by testbenches to fill instruction memory without hand-assembled hex.
- Covers the same opcode set as the single-cycle datapath: R-type, ALU-immediate, lw, sw, beq, lui, jal.

Parameters:
- ADDR_W, 6: width of the instruction-memory word address; capacity is 2**ADDR_W words.
- BASE, 0: first word address written after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted this cycle when in_valid && in_ready.
- in_kind  in  3  0=R, 1=ALU-imm, 2=lw, 3=sw, 4=beq, 5=lui, 6=jal, 7=illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3  used by R and ALU-imm kinds; forced for the other kinds.
- in_funct7b5  in  1  R-kind funct7[5]; for ALU-imm shifts it becomes imm[10].
- in_imm  in  32  signed byte offset or value; lui takes the upper 20 bits.
- out_valid  out  1  encoded word pending.
- out_ready  in  1  consumer (imem write port) takes the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address for out_instr.
- out_err  out  1  qualifies out_instr: encoding error on this word.
- count  out  ADDR_W+1  number of words accepted since reset.
- full  out  1  capacity reached.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_addr=BASE, out_err=0, count=0, full=0. Reset wins over every other event, including a pending unconsumed word, which is discarded.
- Pipeline:
  - One registered stage; latency 1 cycle from acceptance to out_valid.
  - in_ready = !full && (!out_valid || out_ready), so back-to-back throughput is 1 word/cycle.
  - While out_valid && !out_ready, out_instr, out_addr and out_err hold stable.
  - Accept and consume in the same cycle: the register loads the new word and out_valid stays 1.
- Address and count:
  - On each accept, out_addr <= BASE + count (mod 2**ADDR_W) and count increments.
  - When count reaches 2**ADDR_W, full=1 and in_ready=0 until reset. No wrap-over and no silent overwrite; the last word still drains normally.
- Encoding (opcodes and field placement per RV32I):
  - R: 0110011, funct7 = {0, in_funct7b5, 00000}.
  - ALU-imm: 0010011, imm[11:0]=in_imm[11:0]. For funct3 001/101, imm[11:5] = {0, in_funct7b5, 00000} and imm[4:0] = in_imm[4:0].
  - lw: 0000011, funct3 forced to 010.
  - sw: 0100011, funct3 forced to 010, S split of in_imm[11:0].
  - beq: 1100011, funct3 forced to 000, B split of in_imm[12:1].
  - lui: 0110111, in_imm[31:12] placed in bits 31:12.
  - jal: 1101111, J split of in_imm[20:1].
  - Fields unused by a kind are ignored.
- Error rules (word is still emitted and the address still consumed; out_err=1):
  - I/S immediate not representable as sign-extended 12 bits.
  - B immediate not representable as signed 13 bits, or in_imm[0]=1 (bit dropped).
  - J immediate not representable as signed 21 bits, or in_imm[0]=1 (bit dropped).
  - Shift amount in_imm[31:5] != 0.
  - lui with in_imm[11:0] != 0 (low bits dropped).
  - in_kind=7: out_instr = 0x00000013 (nop).

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants matching the decoder: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL;
  - the in_kind enum;
  - NOP_WORD.
- Sub-module rv_imm_pack (combinational): kind + in_imm to placed immediate bits plus range-error flag. The top holds the handshake, output register and address/count logic.

Test Plan:
- ALU-imm rd=1, rs1=0, funct3=000, imm=5 -> 1 cycle later out_valid=1, out_instr=0x00500093, out_addr=0, out_err=0.
- Back-to-back with out_ready=1: lw rd=2, rs1=1, imm=8; sw rs2=2, rs1=1, imm=4; R add rd=3, rs1=1, rs2=2 -> words 0x0080A103, 0x0020A223, 0x002081B3 at addresses 0, 1, 2 on consecutive cycles; count=3.
- beq rs1=1, rs2=2, imm=-4 -> 0xFE208EE3. jal rd=1, imm=8 -> 0x008000EF. jal imm=7 -> out_err=1 with bit0 dropped.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output stable. Release -> drain, then next word 1 cycle later with no word lost or duplicated.
- ADDR_W=2: issue 5 requests -> 4 accepted (addresses 0-3), full=1, in_ready=0. Fifth request never accepted. ALU-imm imm=2048 -> out_err=1. in_kind=7 -> out_instr=0x00000013 with out_err=1.
- Assert reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0, count=0, full=0. The next request lands at address BASE.
